// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - single-port memory arbiter between fetch and load/store stages
module mem_port_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [DW-1:0] if_rdata,
  input  logic          dm_req,
  input  logic          dm_we,
  input  logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_wdata,
  output logic [DW-1:0] dm_rdata,
  output logic          stall,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_ack,
  input  logic [DW-1:0] mem_rdata,
  output logic          mem_err
);

  typedef enum logic [1:0] {IDLE, BUSY_D, BUSY_I} state_t;

  // Abort is decided in the cycle whose count is TIMEOUT-1, so the pipeline
  // sees IDLE exactly TIMEOUT cycles after mem_req first rose.
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

  state_t      state;
  logic        if_served;
  logic        dm_served;
  logic [15:0] wait_cnt;
  logic        timed_out;

  assign timed_out = (wait_cnt >= TO_LAST);
  assign stall     = (if_req & ~if_served) | (dm_req & ~dm_served);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_rdata  <= '0;
      dm_rdata  <= '0;
      if_served <= 1'b0;
      dm_served <= 1'b0;
      wait_cnt  <= '0;
      mem_err   <= 1'b0;
    end else begin
      // Completion below may re-set a flag in the same cycle; that must win.
      if (!stall) begin
        if_served <= 1'b0;
        dm_served <= 1'b0;
      end
      case (state)
        IDLE: begin
          wait_cnt <= '0;
          if (dm_req & ~dm_served) begin
            mem_req   <= 1'b1;
            mem_we    <= dm_we;
            mem_addr  <= dm_addr;
            mem_wdata <= dm_wdata;
            state     <= BUSY_D;
          end else if (if_req & ~if_served) begin
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= if_addr;
            state    <= BUSY_I;
          end
        end
        BUSY_D, BUSY_I: begin
          if (mem_ack || timed_out) begin
            mem_req  <= 1'b0;
            wait_cnt <= '0;
            state    <= IDLE;
            if (!mem_ack) mem_err <= 1'b1;
            if (state == BUSY_I) begin
              if_rdata  <= mem_ack ? mem_rdata : '0;
              if_served <= 1'b1;
            end else begin
              if (!mem_ack) dm_rdata <= '0;
              else if (!mem_we) dm_rdata <= mem_rdata;
              dm_served <= 1'b1;
            end
          end else if (wait_cnt != 16'hFFFF) begin
            wait_cnt <= wait_cnt + 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
